// File: rtl/duty_ramp.sv
// rtl/duty_ramp.sv - slew-rate limiter stepping live PWM duty toward a signed 14-bit target once per tick.
// Optional DUTY_ZERO_CROSS_EN: stop at zero and dwell DWELL_TICKS ticks before reversing direction.
module duty_ramp #(
    parameter int STEP        = 64,
    parameter int TICK_DIV    = 1024,
    parameter int DWELL_TICKS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tgt_vld,
    input  logic [13:0] tgt_duty,
    input  logic        estop,
    output logic [13:0] duty,
    output logic        wrt_duty,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, RAMP, DWELL} state_t;

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0]        TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic signed [14:0]   STEP_S    = 15'(STEP);
    localparam logic [13:0]          STEP_U    = 14'(STEP);

    state_t             state_q, state_d;
    logic [13:0]        cur_q, cur_d;
    logic [13:0]        tgt_q, tgt_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               wrt_q, wrt_d;

    logic               tick;
    logic signed [14:0] diff;
    logic signed [14:0] mag;
    logic [13:0]        stp;
    logic [13:0]        nxt;
    logic [13:0]        cap;

`ifdef DUTY_ZERO_CROSS_EN
    localparam int DCW = $clog2(DWELL_TICKS + 1);
    localparam logic [DCW-1:0] DWELL_LAST = DCW'(DWELL_TICKS - 1);

    logic [DCW-1:0]     dwl_q, dwl_d;
    logic [13:0]        cmag;
    logic               cross;
`endif

    // Widened to 15 bits so a full-scale reversal (+8191 to -8191) cannot wrap.
    assign tick = (cnt_q == TICK_LAST);
    assign diff = {tgt_q[13], tgt_q} - {cur_q[13], cur_q};
    assign mag  = diff[14] ? -diff : diff;
    assign stp  = (mag > STEP_S) ? STEP_U : mag[13:0];
    assign nxt  = diff[14] ? (cur_q - stp) : (cur_q + stp);
    assign cap  = (tgt_duty == 14'h2000) ? 14'h2001 : tgt_duty;

`ifdef DUTY_ZERO_CROSS_EN
    assign cmag  = cur_q[13] ? -cur_q : cur_q;
    assign cross = (cur_q != '0) && (tgt_q != '0) && (cur_q[13] != tgt_q[13]) && (stp >= cmag);
`endif

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        tgt_d   = tgt_q;
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        wrt_d   = 1'b0;
`ifdef DUTY_ZERO_CROSS_EN
        dwl_d   = dwl_q;
`endif
        if (estop) begin
            cur_d   = '0;
            tgt_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
            wrt_d   = |cur_q;
`ifdef DUTY_ZERO_CROSS_EN
            dwl_d   = '0;
`endif
        end else begin
            if (tgt_vld) begin
                tgt_d = cap;
            end
`ifdef DUTY_ZERO_CROSS_EN
            // The dwell length is fixed once entered; only the exit direction follows the latest target.
            if (state_q == DWELL) begin
                if (tick) begin
                    if (dwl_q == DWELL_LAST) begin
                        dwl_d   = '0;
                        state_d = (tgt_d != cur_q) ? RAMP : IDLE;
                    end else begin
                        dwl_d = dwl_q + 1'b1;
                    end
                end
            end else
`endif
            begin
                if (tick && (diff != '0)) begin
                    wrt_d = 1'b1;
                    cur_d = nxt;
                end
                state_d = (cur_d != tgt_d) ? RAMP : IDLE;
`ifdef DUTY_ZERO_CROSS_EN
                if (tick && cross) begin
                    cur_d   = '0;
                    dwl_d   = '0;
                    state_d = DWELL;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cur_q   <= '0;
            tgt_q   <= '0;
            cnt_q   <= '0;
            wrt_q   <= 1'b0;
`ifdef DUTY_ZERO_CROSS_EN
            dwl_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            wrt_q   <= wrt_d;
`ifdef DUTY_ZERO_CROSS_EN
            dwl_q   <= dwl_d;
`endif
        end
    end

    assign duty     = cur_q;
    assign wrt_duty = wrt_q;
    assign busy     = (cur_q != tgt_q) || (state_q == DWELL);

endmodule

// File: tb/tb_duty_ramp.sv
// tb/tb_duty_ramp.sv - self-checking bench for duty_ramp: directed vector table plus random stimulus vs reference model.
module tb_duty_ramp;

    localparam int STEP        = 64;
    localparam int TICK_DIV    = 16;
    localparam int DWELL_TICKS = 2;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        tgt_vld  = 1'b0;
    logic [13:0] tgt_duty = '0;
    logic        estop    = 1'b0;
    logic [13:0] duty;
    logic        wrt_duty;
    logic        busy;

    duty_ramp #(
        .STEP        (STEP),
        .TICK_DIV    (TICK_DIV),
        .DWELL_TICKS (DWELL_TICKS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tgt_vld  (tgt_vld),
        .tgt_duty (tgt_duty),
        .estop    (estop),
        .duty     (duty),
        .wrt_duty (wrt_duty),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Reference model: integer duty/target, cycle count within the tick period, dwell ticks remaining.
    int   m_cur, m_tgt, m_cyc, m_dw;
    logic m_wrt;

    typedef struct {
        int tgt;
        int n;
        int exp[5];
    } vec_t;

    vec_t vecs[3];

    function automatic int to_int(logic [13:0] v);
        return int'($signed(v));
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cur = 0;
        m_tgt = 0;
        m_cyc = 0;
        m_dw  = 0;
        m_wrt = 1'b0;
    endtask

    task automatic model_step();
        int   t_new, delta, mv, nc;
        logic tick;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (estop) begin
            m_wrt = (m_cur != 0);
            m_cur = 0;
            m_tgt = 0;
            m_cyc = 0;
            m_dw  = 0;
            return;
        end
        tick  = (m_cyc == TICK_DIV - 1);
        m_cyc = (m_cyc + 1) % TICK_DIV;
        m_wrt = 1'b0;
        t_new = tgt_vld ? to_int(tgt_duty) : m_tgt;
        if (t_new == -8192) t_new = -8191;
        if (tick) begin
            if (m_dw > 0) begin
                m_dw--;
            end else if (m_cur != m_tgt) begin
                delta = m_tgt - m_cur;
                mv    = (delta < 0) ? -delta : delta;
                if (mv > STEP) mv = STEP;
                nc    = (delta < 0) ? m_cur - mv : m_cur + mv;
`ifdef DUTY_ZERO_CROSS_EN
                if (m_cur != 0 && m_tgt != 0 && ((m_cur > 0) != (m_tgt > 0)) &&
                    (nc == 0 || ((nc > 0) != (m_cur > 0)))) begin
                    nc   = 0;
                    m_dw = DWELL_TICKS;
                end
`endif
                m_wrt = 1'b1;
                m_cur = nc;
            end
        end
        m_tgt = t_new;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("model duty", to_int(duty), m_cur);
        chk("model wrt_duty", int'(wrt_duty), int'(m_wrt));
        chk("model busy", int'(busy), int'((m_cur != m_tgt) || (m_dw > 0)));
    endtask

    task automatic wait_strobe(string name);
        for (int k = 0; k < 40 * TICK_DIV; k++) begin
            cyc();
            if (wrt_duty) return;
        end
        checks++;
        fails++;
        $display("FAIL %s: no wrt_duty within %0d cycles", name, 40 * TICK_DIV);
    endtask

    task automatic load(int v);
        tgt_duty = 14'(v);
        tgt_vld  = 1'b1;
        cyc();
        tgt_vld  = 1'b0;
    endtask

    initial begin
        int nw, n;

        vecs[0].tgt = 200;
        vecs[0].n   = 4;
        vecs[0].exp = '{64, 128, 192, 200, 0};
        vecs[1].tgt = 100;
        vecs[1].n   = 2;
        vecs[1].exp = '{136, 100, 0, 0, 0};
        vecs[2].tgt = -100;
        vecs[2].n   = 4;
`ifdef DUTY_ZERO_CROSS_EN
        vecs[2].exp = '{36, 0, -64, -100, 0};
`else
        vecs[2].exp = '{36, -28, -92, -100, 0};
`endif

        model_reset();
        @(negedge clk);
        chk("reset duty", to_int(duty), 0);
        chk("reset wrt_duty", int'(wrt_duty), 0);
        chk("reset busy", int'(busy), 0);
        repeat (3) cyc();
        rst_n = 1'b1;

        nw = 0;
        repeat (100) begin
            cyc();
            if (wrt_duty) nw++;
        end
        chk("idle strobes", nw, 0);
        chk("idle duty", to_int(duty), 0);
        chk("idle busy", int'(busy), 0);

        for (int i = 0; i < 3; i++) begin
            load(vecs[i].tgt);
            for (int j = 0; j < vecs[i].n; j++) begin
                wait_strobe($sformatf("vec%0d strobe%0d", i, j));
                chk($sformatf("vec%0d step%0d duty", i, j), to_int(duty), vecs[i].exp[j]);
            end
            chk($sformatf("vec%0d busy at last step", i), int'(busy), 0);
            nw = 0;
            repeat (3 * TICK_DIV) begin
                cyc();
                if (wrt_duty) nw++;
            end
            chk($sformatf("vec%0d extra strobes", i), nw, 0);
        end

        load(-8192);
        n = 0;
        while (busy && n < 200 * TICK_DIV) begin
            cyc();
            n++;
        end
        chk("clamp busy", int'(busy), 0);
        chk("clamp duty", to_int(duty), -8191);

        estop = 1'b1;
        cyc();
        chk("estop full duty", to_int(duty), 0);
        chk("estop full wrt", int'(wrt_duty), 1);
        cyc();
        chk("estop zero wrt", int'(wrt_duty), 0);
        estop = 1'b0;

        load(200);
        wait_strobe("estop ramp s1");
        wait_strobe("estop ramp s2");
        chk("estop pre duty", to_int(duty), 128);
        estop = 1'b1;
        cyc();
        chk("estop duty", to_int(duty), 0);
        chk("estop wrt", int'(wrt_duty), 1);
        chk("estop busy", int'(busy), 0);
        estop    = 1'b0;
        tgt_duty = 14'd40;
        tgt_vld  = 1'b1;
        cyc();
        tgt_vld  = 1'b0;
        n = 1;
        while (!wrt_duty && n < 4 * TICK_DIV) begin
            cyc();
            n++;
        end
        chk("estop tick spacing", n, 16);
        chk("estop next duty", to_int(duty), 40);

        estop = 1'b1;
        cyc();
        estop = 1'b0;
        load(100);
        wait_strobe("simul first");
        chk("simul first duty", to_int(duty), 64);
        repeat (TICK_DIV - 1) cyc();
        load(300);
        chk("simul tick duty", to_int(duty), 100);
        chk("simul tick wrt", int'(wrt_duty), 1);
        for (int j = 0; j < 4; j++) begin
            wait_strobe("simul ramp");
            chk($sformatf("simul step%0d duty", j), to_int(duty), 164 + 64 * j - ((j == 3) ? 56 : 0));
        end

        load(500);
        wait_strobe("rst ramp");
        repeat (5) cyc();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async rst duty", to_int(duty), 0);
        chk("async rst wrt", int'(wrt_duty), 0);
        chk("async rst busy", int'(busy), 0);
        repeat (3) cyc();
        rst_n = 1'b1;

        for (int k = 0; k < 3000; k++) begin
            int r;
            r       = int'($urandom_range(0, 199));
            estop   = (r == 0);
            tgt_vld = (r >= 1 && r <= 4);
            case ($urandom_range(0, 3))
                0:       tgt_duty = 14'h2000;
                1:       tgt_duty = 14'($urandom);
                default: tgt_duty = 14'($urandom_range(0, 600) - 300);
            endcase
            cyc();
        end
        estop   = 1'b0;
        tgt_vld = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
